// File: rtl/kronos_bus_arbiter_pkg.sv
// kronos_types: shared arbiter state encoding and bus constants for the Kronos memory bus.
package kronos_types;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
    localparam logic [31:0] BUS_ERR_DATA = 32'h0;
endpackage

// File: rtl/kronos_bus_arbiter_watchdog.sv
// kronos_bus_watchdog: per-grant timer that flags a hung access after TIMEOUT cycles.
module kronos_bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ack,
    output logic timeout
);
    localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit ON = TIMEOUT != 0;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    logic [TW-1:0] timer;
    // Held at zero outside a grant, so every grant starts counting from 0.
    always_ff @(posedge clk)
        if (rst || !ON || !active || mem_ack || timeout) timer <= '0;
        else timer <= timer + 1'b1;
    assign timeout = ON && active && !mem_ack && (timer == LAST);
endmodule

// File: rtl/kronos_bus_arbiter.sv
// kronos_bus_arbiter: shares one memory bus between fetch and LSU, data-first with a fetch anti-starvation streak limit.
module kronos_bus_arbiter
    import kronos_types::*;
#(
    parameter int          MAX_STREAK = 4,
    parameter int          TIMEOUT    = 64,
    parameter logic [31:0] ERR_DATA   = BUS_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack,
    output logic        bus_err
);
    localparam int SW = (MAX_STREAK == 0) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    arb_state_t state, state_next;
    logic [SW-1:0] streak, streak_next;
    logic force_i, timeout, done, gnt_i, gnt_d;
    assign force_i = instr_req && (MAX_STREAK != 0) && (streak == STREAK_MAX);
    assign done = mem_ack || timeout;
    assign gnt_i = state == ARB_GNT_I;
    assign gnt_d = state == ARB_GNT_D;
    kronos_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (state != ARB_IDLE),
        .mem_ack (mem_ack),
        .timeout (timeout)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state  <= ARB_IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    // Streak counts data grants taken while fetch was kept waiting.
    always_comb begin
        state_next  = state;
        streak_next = streak;
        if (state == ARB_IDLE) begin
            if (data_req && !force_i) begin
                state_next  = ARB_GNT_D;
                streak_next = !instr_req ? '0 : (streak == STREAK_MAX) ? streak : streak + 1'b1;
            end else if (instr_req) begin
                state_next  = ARB_GNT_I;
                streak_next = '0;
            end
        end else if (done) begin
            state_next = ARB_IDLE;
        end
    end
    always_comb begin
        mem_req      = state != ARB_IDLE;
        mem_addr     = gnt_i ? instr_addr : gnt_d ? data_addr : '0;
        mem_wr_data  = gnt_d ? data_wr_data : '0;
        mem_mask     = gnt_i ? 4'hF : gnt_d ? data_mask : 4'h0;
        mem_wr_en    = gnt_d && data_wr_en;
        instr_ack    = gnt_i && done;
        data_ack     = gnt_d && done;
        instr_data   = mem_ack ? mem_rd_data : ERR_DATA;
        data_rd_data = mem_ack ? mem_rd_data : ERR_DATA;
        bus_err      = timeout;
    end
endmodule
